// File: rtl/ts_tx_arb_if.sv
// Bundle of TS generator, LTSSM and TX FIFO signals seen by ts_tx_arb.
// slave is the arbiter's view; master is the driving environment's view.
interface ts_tx_arb_if;
  logic         ts_valid;
  logic [127:0] ts;
  logic         ts_ready;
  logic         eios_req;
  logic [1:0]   eios_cnt;
  logic         eios_done;
  logic         tx_elec_idle;
  logic         skp_pending;
  logic         fifo_wr;
  logic [127:0] fifo_data;
  logic         ts_tx_fifo_full;

  modport master (
    output ts_valid, ts, eios_req, eios_cnt, ts_tx_fifo_full,
    input  ts_ready, eios_done, tx_elec_idle, skp_pending, fifo_wr, fifo_data
  );

  modport slave (
    input  ts_valid, ts, eios_req, eios_cnt, ts_tx_fifo_full,
    output ts_ready, eios_done, tx_elec_idle, skp_pending, fifo_wr, fifo_data
  );
endinterface

// File: rtl/ts_tx_arb.sv
// Ordered-set arbiter sharing the TX FIFO write port among TS, SKP and EIOS words.
// Define TS_SKP_SCHED_EN to build the periodic SKP scheduler; without it no SKP is ever sent.
module ts_tx_arb #(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned CNT_W        = 12
) (
  input  logic       clk,
  input  logic       rst,
  ts_tx_arb_if.slave bus
);
  localparam logic [127:0] SKP_WORD  = {4{32'hBC1C1C1C}};
  localparam logic [127:0] EIOS_WORD = {4{32'hBC7C7C7C}};

  typedef enum logic [1:0] {S_IDLE, S_EIOS, S_EIDLE} state_t;

  state_t       r_state;
  state_t       w_nxt_state;
  logic [2:0]   r_eios_left;
  logic         r_eios_pend;
  logic [1:0]   r_pend_cnt;
  logic         r_fifo_wr;
  logic [127:0] r_fifo_data;
  logic         r_eios_done;

  logic         w_skp_pending;
  logic         w_eios_any;
  logic         w_ts_ready;
  logic         w_ts_grant;
  logic         w_skp_grant;
  logic         w_eios_grant;
  logic         w_eios_last;
  logic         w_grant;
  logic [127:0] w_word;

  assign w_eios_any = bus.eios_req | r_eios_pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE:  if (w_eios_any)   w_nxt_state = S_EIOS;
      S_EIOS:  if (w_eios_last)  w_nxt_state = S_EIDLE;
      S_EIDLE: if (bus.ts_valid) w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // An EIOS request in IDLE only blocks the other sources; EIOS words are issued from S_EIOS.
  always_comb begin
    w_ts_ready   = 1'b0;
    w_skp_grant  = 1'b0;
    w_eios_grant = 1'b0;
    w_eios_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ts_ready  = !bus.ts_tx_fifo_full && !w_skp_pending && !w_eios_any;
        w_skp_grant = !bus.ts_tx_fifo_full &&  w_skp_pending && !w_eios_any;
      end
      S_EIOS: begin
        w_eios_grant = !bus.ts_tx_fifo_full;
        w_eios_last  = w_eios_grant && (r_eios_left == 3'd1);
      end
      default: ;
    endcase
    w_ts_grant = w_ts_ready && bus.ts_valid;
    w_grant    = w_ts_grant || w_skp_grant || w_eios_grant;
    w_word     = bus.ts;
    if (w_eios_grant)     w_word = EIOS_WORD;
    else if (w_skp_grant) w_word = SKP_WORD;
  end

  // A request arriving outside IDLE is parked with its count until IDLE is re-entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_eios_left <= 3'd0;
      r_eios_pend <= 1'b0;
      r_pend_cnt  <= 2'd0;
    end else if (r_state == S_IDLE && w_eios_any) begin
      r_eios_left <= bus.eios_req ? ({1'b0, bus.eios_cnt} + 3'd1)
                                  : ({1'b0, r_pend_cnt} + 3'd1);
      r_eios_pend <= 1'b0;
    end else begin
      if (w_eios_grant) r_eios_left <= r_eios_left - 3'd1;
      if (bus.eios_req) begin
        r_eios_pend <= 1'b1;
        r_pend_cnt  <= bus.eios_cnt;
      end
    end
  end

  // Write port register: grant in cycle N is written in cycle N+1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo_wr   <= 1'b0;
      r_fifo_data <= '0;
      r_eios_done <= 1'b0;
    end else begin
      r_fifo_wr   <= w_grant;
      r_eios_done <= w_eios_last;
      if (w_grant) r_fifo_data <= w_word;
    end
  end

`ifdef TS_SKP_SCHED_EN
  logic [CNT_W-1:0] r_skp_cnt;
  logic             r_skp_pend;
  logic             w_wrap;

  assign w_wrap = (r_skp_cnt == CNT_W'(SKP_INTERVAL - 1));

  // Wrap is evaluated after the grant clear so a coincident wrap re-arms pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_skp_cnt  <= '0;
      r_skp_pend <= 1'b0;
    end else if (r_state == S_EIDLE || w_nxt_state == S_EIDLE) begin
      r_skp_cnt  <= '0;
      r_skp_pend <= 1'b0;
    end else begin
      r_skp_cnt <= w_wrap ? '0 : r_skp_cnt + CNT_W'(1);
      if (w_wrap)           r_skp_pend <= 1'b1;
      else if (w_skp_grant) r_skp_pend <= 1'b0;
    end
  end

  assign w_skp_pending = r_skp_pend;
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = ^{SKP_INTERVAL, CNT_W};
  assign w_skp_pending = 1'b0;
`endif

  assign bus.ts_ready     = w_ts_ready;
  assign bus.skp_pending  = w_skp_pending;
  assign bus.fifo_wr      = r_fifo_wr;
  assign bus.fifo_data    = r_fifo_data;
  assign bus.eios_done    = r_eios_done;
  assign bus.tx_elec_idle = (r_state == S_EIDLE);
endmodule

// File: tb/tb_ts_tx_arb.sv
// Self-checking bench for ts_tx_arb: per-cycle vector table plus hand sequences,
// with a write scoreboard; SKP scenarios run only when TS_SKP_SCHED_EN is defined.
module tb_ts_tx_arb;
  localparam int G_NONE = 0;
  localparam int G_TS   = 1;
  localparam int G_EIOS = 2;
  localparam int G_SKP  = 3;
  localparam logic [127:0] SKP_W  = {4{32'hBC1C1C1C}};
  localparam logic [127:0] EIOS_W = {4{32'hBC7C7C7C}};

  typedef struct packed { logic [127:0] data; logic done; } exp_t;
  typedef struct {
    logic tv; logic req; logic [1:0] cnt; logic full;
    logic rdy; int g; logic done; logic eidle;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int unsigned ts_seq = 0;
  exp_t sb_q[$];

  ts_tx_arb_if bus();

  ts_tx_arb #(.SKP_INTERVAL(16), .CNT_W(12)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic chki(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [127:0] mk_ts(input int unsigned n);
    return {32'hDA7A0000 ^ n, n, ~n, n * 32'd2654435761};
  endfunction

  // Every observed write must match the oldest expected word.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (bus.fifo_wr) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got %h want no write at %0t", bus.fifo_data, $time);
        end else begin
          e = sb_q.pop_front();
          chkw("fifo_data", bus.fifo_data, e.data);
          chk1("eios_done_on_write", bus.eios_done, e.done);
        end
      end else if (bus.eios_done) begin
        chk1("eios_done_without_write", bus.eios_done, 1'b0);
      end
    end
  end

  task automatic drive_idle();
    bus.ts_valid        = 1'b0;
    bus.ts              = '0;
    bus.eios_req        = 1'b0;
    bus.eios_cnt        = 2'd0;
    bus.ts_tx_fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one cycle, checks combinational/state outputs and records the expected write.
  task automatic cyc(input logic tv, input logic req, input logic [1:0] cnt, input logic full,
                     input logic rdy, input int g, input logic done, input logic eidle,
                     input logic skp);
    logic [127:0] tsw;
    tsw = mk_ts(ts_seq);
    ts_seq++;
    bus.ts_valid        = tv;
    bus.ts              = tsw;
    bus.eios_req        = req;
    bus.eios_cnt        = cnt;
    bus.ts_tx_fifo_full = full;
    #1;
    chk1("ts_ready", bus.ts_ready, rdy);
    chk1("tx_elec_idle", bus.tx_elec_idle, eidle);
    chk1("skp_pending", bus.skp_pending, skp);
    case (g)
      G_TS:    sb_q.push_back('{data: tsw,    done: 1'b0});
      G_EIOS:  sb_q.push_back('{data: EIOS_W, done: done});
      G_SKP:   sb_q.push_back('{data: SKP_W,  done: 1'b0});
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  // Blocks new grants so already-granted words drain, then the scoreboard must be empty.
  task automatic drain(input string name);
    drive_idle();
    bus.ts_tx_fifo_full = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chki(name, sb_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, G_TS,   1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, G_TS,   1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, G_NONE, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_EIOS, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, G_NONE, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_EIOS, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_EIOS, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, G_TS,   1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, G_NONE, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, G_NONE, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b0, G_EIOS, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_EIOS, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_EIOS, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b1};

    // Reset values.
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_fifo_wr", bus.fifo_wr, 1'b0);
    chkw("rst_fifo_data", bus.fifo_data, '0);
    chk1("rst_skp_pending", bus.skp_pending, 1'b0);
    chk1("rst_eios_done", bus.eios_done, 1'b0);
    chk1("rst_tx_elec_idle", bus.tx_elec_idle, 1'b0);

    // Vector table: TS, EIOS x3 with a full stall, EIDLE exit, deferred EIOS request.
    do_reset();
    for (int i = 0; i < 21; i++)
      cyc(tbl[i].tv, tbl[i].req, tbl[i].cnt, tbl[i].full,
          tbl[i].rdy, tbl[i].g, tbl[i].done, tbl[i].eidle, 1'b0);
    drain("drain_table");

    // Reset after the first of four EIOS words: remainder and eios_done are abandoned.
    do_reset();
    cyc(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, G_NONE, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, G_EIOS, 1'b0, 1'b0, 1'b0);
    // The second word is granted here but reset lands before it is written.
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("midrst_fifo_wr", bus.fifo_wr, 1'b0);
    chkw("midrst_fifo_data", bus.fifo_data, '0);
    chk1("midrst_eios_done", bus.eios_done, 1'b0);
    chk1("midrst_tx_elec_idle", bus.tx_elec_idle, 1'b0);
    chk1("midrst_skp_pending", bus.skp_pending, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++)
      cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, G_NONE, 1'b0, 1'b0, 1'b0);
    drain("drain_midrst");

`ifdef TS_SKP_SCHED_EN
    // Continuous TS: one SKP every 16 cycles, ts_ready low in the SKP grant cycle.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      logic s;
      s = (c > 0) && (c % 16 == 0);
      cyc(1'b1, 1'b0, 2'd0, 1'b0, !s, s ? G_SKP : G_TS, 1'b0, 1'b0, s);
    end
    drain("drain_skp_stream");

    // 40 full cycles: no writes, one SKP owed, then SKP before TS on release.
    do_reset();
    for (int c = 0; c < 40; c++)
      cyc(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, G_NONE, 1'b0, 1'b0, c >= 16);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_SKP, 1'b0, 1'b0, 1'b1);
    for (int c = 41; c < 46; c++)
      cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, G_TS, 1'b0, 1'b0, 1'b0);
    drain("drain_full_hold");

    // EIOS request coinciding with counter wrap and ts_valid.
    do_reset();
    for (int c = 0; c < 15; c++)
      cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, G_TS, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_EIOS, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, G_NONE, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, G_TS, 1'b0, 1'b0, 1'b0);
    drain("drain_eios_wrap");
`else
    // Without the scheduler a long TS stream never yields SKP.
    do_reset();
    for (int c = 0; c < 5000; c++)
      cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, G_TS, 1'b0, 1'b0, 1'b0);
    drain("drain_no_skp");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ts_tx_arb.md
# ts_tx_arb

Transmit-side ordered-set arbiter sitting between the TS generator, the LTSSM and the 128-bit TX FIFO. It shares the single FIFO write port between three sources: TS words from the TS generator, periodically scheduled SKP words and LTSSM-requested EIOS words. It places the link in electrical idle after EIOS. One 128-bit word is written per cycle at most, and a word is never split.

## Interface
- `SKP_INTERVAL`, 1180: clock cycles between SKP schedule events.
- `CNT_W`, 12: width of SKP interval counter; must hold `SKP_INTERVAL-1`.
- `clk` in 1: 1 GHz system clock.
- `rst` in 1: asynchronous, active-low reset.
- `ts_valid` in 1: TS generator has a word on `ts`.
- `ts` in 128: TS word.
- `ts_ready` out 1: TS word accepted this cycle when `ts_valid & ts_ready`.
- `eios_req` in 1: single-cycle request to send EIOS and enter electrical idle.
- `eios_cnt` in 2: number of EIOS words minus 1; sampled with `eios_req`.
- `eios_done` out 1: one-cycle pulse after the last EIOS word is written.
- `tx_elec_idle` out 1: high while in electrical idle.
- `skp_pending` out 1: SKP word owed.
- `fifo_wr` out 1: FIFO write strobe.
- `fifo_data` out 128: FIFO write data.
- `ts_tx_fifo_full` in 1: FIFO full; no write is issued when high.

## Operation
- Constant words: SKP_WORD = {4{32'hBC1C1C1C}}, EIOS_WORD = {4{32'hBC7C7C7C}}.
- States: IDLE, EIOS, EIDLE. There is no separate TS or SKP state; both are handled per word in IDLE.
- Per-cycle priority in IDLE when `ts_tx_fifo_full`=0: EIOS (`eios_req` or latched `eios_pend`) > SKP (`skp_pending`) > TS.
- `ts_ready` = state==IDLE & !`ts_tx_fifo_full` & !`skp_pending` & !`eios_req` & !`eios_pend`. It is combinational and independent of `ts_valid`.
- SKP grant writes SKP_WORD and clears `skp_pending`.
- On `eios_req`, latch `eios_left` = `eios_cnt`+1, then go to EIOS. If `eios_req` occurs while not in IDLE, latch it into `eios_pend`. It is served on return to IDLE.
- EIOS state: write EIOS_WORD on each cycle the FIFO is not full and decrement `eios_left`. After the last write, pulse `eios_done` and go to EIDLE. SKP is not inserted between EIOS words.
- EIDLE: `tx_elec_idle`=1, no writes, SKP counter held at 0, `skp_pending` cleared. The first cycle with `ts_valid`=1 returns to IDLE, with `ts_ready` low in that cycle. Normal arbitration resumes on the next cycle.
- SKP counter: counts 0..`SKP_INTERVAL`-1 in IDLE and EIOS, then wraps and sets `skp_pending`. If `skp_pending` is already set at wrap, it stays set and does not count twice.

## Timing
- Reset (`rst`=0, async): state IDLE. `fifo_wr`=0, `fifo_data`=0, `skp_pending`=0, `eios_done`=0, `tx_elec_idle`=0, counter 0, `eios_pend`=0.
- `fifo_wr`/`fifo_data` are registered. A grant in cycle N produces a write in cycle N+1 (latency 1). `ts_tx_fifo_full` is sampled in grant cycle N.
- A full FIFO blocks every grant, so no word is lost or duplicated. The counter keeps running while the FIFO is full.
- Simultaneous `eios_req` and `ts_valid` in IDLE: EIOS wins and the TS word is not consumed.
- Simultaneous counter wrap and SKP grant: the wrap sets `skp_pending` again after the clear (set wins).
- `eios_done` is high exactly one cycle, aligned with the cycle `fifo_wr` writes the final EIOS word.
- Reset mid-EIOS abandons the remaining words. No `eios_done` is issued.

## Configuration
- `TS_SKP_SCHED_EN` defined: SKP counter and SKP insertion present as above.
- Not defined: no counter, `skp_pending` tied to 0, SKP_WORD is never written, `SKP_INTERVAL`/`CNT_W` are unused. All other behaviour is unchanged.

## Test plan
- Reset, then continuous `ts_valid` with FIFO never full, `SKP_INTERVAL`=16 -> one TS word per cycle and one SKP_WORD every 16 cycles. `ts_ready` is low in the SKP grant cycle.
- `eios_cnt`=2, `eios_req` pulse during TS stream -> 3 consecutive EIOS_WORD writes. `eios_done` is high on the third write, then `tx_elec_idle`=1. No writes until `ts_valid` occurs, and TS resumes one cycle after it.
- Hold `ts_tx_fifo_full`=1 for 40 cycles with `SKP_INTERVAL`=16 -> zero writes and `skp_pending`=1. After release, exactly one SKP_WORD is written first, then TS.
- `eios_req` in the same cycle as counter wrap and `ts_valid` -> EIOS_WORD is written first. `skp_pending` is cleared on entry to EIDLE, and no SKP_WORD is written.
- Assert `rst` mid-EIOS (`eios_cnt`=3, after 1 word) -> all outputs go to 0 immediately and `eios_done` is never pulsed.
- Build without `TS_SKP_SCHED_EN`, 5000 cycles of TS -> `skp_pending` stays 0 and no SKP_WORD is written.
